// File: rtl/pio_pkg.sv
// Shared constants for the edge-capturing PIO input port: register map,
// edge-select encodings and interrupt source modes.
package pio_pkg;

  typedef enum logic [1:0] {
    ADDR_DATA = 2'd0,
    ADDR_RSVD = 2'd1,
    ADDR_MASK = 2'd2,
    ADDR_EDGE = 2'd3
  } reg_addr_e;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  localparam int IRQ_EDGE  = 0;
  localparam int IRQ_LEVEL = 1;

endpackage

// File: rtl/pio_sync_cell.sv
// Single-bit multi-flop synchroniser for one asynchronous PIO input.
module pio_sync_cell #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] stg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stg <= '0;
    else          stg <= {stg[SYNC_STAGES-2:0], d};
  end

  assign q = stg[SYNC_STAGES-1];

endmodule

// File: rtl/pio_edge_capture_in.sv
// Avalon-MM input PIO: synchronised level readback, sticky W1C edge capture
// and a maskable, registered interrupt.
module pio_edge_capture_in
  import pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISE,
  parameter int IRQ_MODE    = IRQ_EDGE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int WU_MAX = SYNC_STAGES + 1;
  localparam int WU_W   = $clog2(WU_MAX + 1);

  logic [WIDTH-1:0] sync_out, prev, irqmask, edgecapture, det, clr, irq_src;
  logic [WU_W-1:0]  wu_cnt;
  logic             warm, wr;
  logic [31:0]      rd_mux;

  for (genvar i = 0; i < WIDTH; i++) begin : g_sync
    pio_sync_cell #(.SYNC_STAGES(SYNC_STAGES)) u_cell (
      .clk    (clk),
      .reset_n(reset_n),
      .d      (in_port[i]),
      .q      (sync_out[i])
    );
  end

  // Detection stays off until the synchroniser and prev hold real samples,
  // so a line already high at reset release is not seen as an edge.
  assign warm = (wu_cnt == WU_W'(WU_MAX));
  assign wr   = chipselect & ~write_n;
  assign clr  = (wr && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;

  always_comb begin
    det = sync_out & ~prev;
    if (EDGE_TYPE == EDGE_FALL)     det = ~sync_out & prev;
    else if (EDGE_TYPE == EDGE_ANY) det = sync_out ^ prev;
    if (!warm) det = '0;
  end

  assign irq_src = (IRQ_MODE == IRQ_LEVEL) ? (sync_out & irqmask)
                                           : (edgecapture & irqmask);

  always_comb begin
    rd_mux = '0;
    case (reg_addr_e'(address))
      ADDR_DATA: rd_mux[WIDTH-1:0] = sync_out;
      ADDR_MASK: rd_mux[WIDTH-1:0] = irqmask;
      ADDR_EDGE: rd_mux[WIDTH-1:0] = edgecapture;
      default:   rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev        <= '0;
      wu_cnt      <= '0;
      irqmask     <= '0;
      edgecapture <= '0;
      readdata    <= '0;
      irq         <= 1'b0;
    end else begin
      prev <= sync_out;
      if (!warm) wu_cnt <= wu_cnt + WU_W'(1);
      if (wr && address == ADDR_MASK) irqmask <= writedata[WIDTH-1:0];
      // A new edge on a bit being cleared this cycle keeps the bit set.
      edgecapture <= (edgecapture & ~clr) | det;
      readdata    <= rd_mux;
      irq         <= |irq_src;
    end
  end

endmodule

// File: tb/tb_pio_edge_capture_in.sv
// Bench for pio_edge_capture_in: four variants (rise, fall, any, level irq)
// share one bus and input vector and are checked against a history model.
module tb_pio_edge_capture_in;
  localparam int W  = 8;
  localparam int SS = 2;
  localparam int NI = 4;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [1:0]        address = '0;
  logic              chipselect = 1'b0;
  logic              write_n = 1'b1;
  logic [31:0]       writedata = '0;
  logic [W-1:0]      in_port = '0;
  logic [NI-1:0][31:0] rd;
  logic [NI-1:0]     irq_o;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    pio_edge_capture_in #(
      .WIDTH(W), .SYNC_STAGES(SS),
      .EDGE_TYPE(g == 3 ? 0 : g), .IRQ_MODE(g == 3 ? 1 : 0)
    ) u_dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(rd[g]), .irq(irq_o[g])
    );
  end

  // Model: m_h[n] is the input sampled n+1 clocks ago; the synchronised level
  // is the sample SS clocks old and its predecessor is one clock older.
  logic [W-1:0]  m_h [0:SS];
  int            m_cnt;
  logic [W-1:0]  m_mask;
  logic [W-1:0]  m_ec [NI];
  logic [31:0]   m_rd [NI];
  logic [NI-1:0] m_irq;

  function automatic logic [W-1:0] edges(int et, logic [W-1:0] s, logic [W-1:0] p);
    if (et == 0) return s & ~p;
    if (et == 1) return ~s & p;
    return s ^ p;
  endfunction

  task automatic model_reset();
    for (int i = 0; i <= SS; i++) m_h[i] = '0;
    m_cnt = 0; m_mask = '0; m_irq = '0;
    for (int k = 0; k < NI; k++) begin m_ec[k] = '0; m_rd[k] = '0; end
  endtask

  task automatic cycle();
    logic [W-1:0] s, p, clr;
    if (!reset_n) model_reset();
    else begin
      s = m_h[SS-1]; p = m_h[SS];
      clr = (chipselect && !write_n && address == 2'd3) ? writedata[W-1:0] : '0;
      for (int k = 0; k < NI; k++) begin
        m_rd[k]  = address == 2'd0 ? 32'(s) : address == 2'd2 ? 32'(m_mask) :
                   address == 2'd3 ? 32'(m_ec[k]) : 32'd0;
        m_irq[k] = (k == 3) ? |(s & m_mask) : |(m_ec[k] & m_mask);
        m_ec[k]  = (m_ec[k] & ~clr) |
                   ((m_cnt >= SS + 1) ? edges(k == 3 ? 0 : k, s, p) : '0);
      end
      if (chipselect && !write_n && address == 2'd2) m_mask = writedata[W-1:0];
      for (int i = SS; i > 0; i--) m_h[i] = m_h[i-1];
      m_h[0] = in_port;
      if (m_cnt < SS + 1) m_cnt++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    cycle();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_port = '1; address = 2'd0;
    model_reset();
    #1;
    for (int k = 0; k < NI; k++) begin
      n_chk++;
      if (rd[k] !== 32'd0 || irq_o[k] !== 1'b0) begin
        n_fail++; $display("FAIL reset dut%0d rd=%h irq=%b want rd=0 irq=0", k, rd[k], irq_o[k]);
      end
    end
    @(negedge clk); reset_n = 1'b1;
    repeat (6) begin
      cycle();
      for (int k = 0; k < NI; k++) begin
        n_chk++;
        if (rd[k] !== m_rd[k] || irq_o[k] !== m_irq[k]) begin
          n_fail++; $display("FAIL warmup dut%0d rd=%h irq=%b want rd=%h irq=%b", k, rd[k], irq_o[k], m_rd[k], m_irq[k]);
        end
      end
      n_chk++;
      if (irq_o[0] !== 1'b0) begin n_fail++; $display("FAIL warmup_irq got %b want 0", irq_o[0]); end
    end
    n_chk++;
    if (rd[0] !== 32'hFF) begin n_fail++; $display("FAIL data_ff got %h want 000000ff", rd[0]); end
    address = 2'd3; cycle();
    for (int k = 0; k < NI; k++) begin
      n_chk++;
      if (rd[k] !== 32'd0) begin n_fail++; $display("FAIL no_spurious dut%0d got %h want 0", k, rd[k]); end
    end
  endtask

  task automatic test_rise();
    in_port = '0; repeat (4) cycle();
    bus_write(2'd3, 32'hFF); bus_write(2'd2, 32'h05);
    address = 2'd3; cycle();
    in_port[0] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) in_port[0] = 1'b0;
      cycle();
      for (int k = 0; k < NI; k++) begin
        n_chk++;
        if (rd[k] !== m_rd[k] || irq_o[k] !== m_irq[k]) begin
          n_fail++; $display("FAIL rise_seq dut%0d rd=%h irq=%b want rd=%h irq=%b", k, rd[k], irq_o[k], m_rd[k], m_irq[k]);
        end
      end
    end
    n_chk++;
    if (rd[0] !== 32'h1 || irq_o[0] !== 1'b1) begin
      n_fail++; $display("FAIL rise_capture rd=%h irq=%b want rd=1 irq=1", rd[0], irq_o[0]);
    end
    bus_write(2'd3, 32'h1);
    n_chk++;
    if (rd[0] !== 32'h1 || irq_o[0] !== 1'b1) begin
      n_fail++; $display("FAIL read_preclear rd=%h irq=%b want rd=1 irq=1", rd[0], irq_o[0]);
    end
    cycle();
    n_chk++;
    if (rd[0] !== 32'h0 || irq_o[0] !== 1'b0) begin
      n_fail++; $display("FAIL clear rd=%h irq=%b want rd=0 irq=0", rd[0], irq_o[0]);
    end
  endtask

  task automatic test_set_wins();
    address = 2'd3;
    in_port[2] = 1'b1;
    cycle(); cycle();
    bus_write(2'd3, 32'h4);
    cycle();
    for (int k = 0; k < NI; k++) begin
      n_chk++;
      if (rd[k] !== m_rd[k] || irq_o[k] !== m_irq[k]) begin
        n_fail++; $display("FAIL set_wins_model dut%0d rd=%h irq=%b want rd=%h irq=%b", k, rd[k], irq_o[k], m_rd[k], m_irq[k]);
      end
    end
    n_chk++;
    if (rd[0][2] !== 1'b1 || irq_o[0] !== 1'b1) begin
      n_fail++; $display("FAIL set_wins rd=%h irq=%b want bit2=1 irq=1", rd[0], irq_o[0]);
    end
    in_port[2] = 1'b0; repeat (4) cycle();
  endtask

  task automatic test_any();
    bus_write(2'd2, 32'h0); bus_write(2'd3, 32'hFF);
    address = 2'd3;
    in_port[7] = 1'b1; repeat (5) cycle();
    n_chk++;
    if (rd[2][7] !== 1'b1) begin n_fail++; $display("FAIL any_rise got %h want bit7=1", rd[2]); end
    n_chk++;
    if (irq_o[2] !== 1'b0) begin n_fail++; $display("FAIL any_masked got %b want 0", irq_o[2]); end
    bus_write(2'd3, 32'h80); cycle();
    n_chk++;
    if (rd[2][7] !== 1'b0) begin n_fail++; $display("FAIL any_cleared got %h want bit7=0", rd[2]); end
    in_port[7] = 1'b0; repeat (5) cycle();
    n_chk++;
    if (rd[2][7] !== 1'b1 || rd[1][7] !== 1'b1) begin
      n_fail++; $display("FAIL any_fall any=%h fall=%h want bit7=1", rd[2], rd[1]);
    end
    bus_write(2'd2, 32'h80);
    n_chk++;
    if (irq_o[2] !== 1'b0) begin n_fail++; $display("FAIL mask_delay got %b want 0", irq_o[2]); end
    cycle();
    n_chk++;
    if (irq_o[2] !== 1'b1) begin n_fail++; $display("FAIL mask_irq got %b want 1", irq_o[2]); end
  endtask

  task automatic test_level();
    bus_write(2'd2, 32'h1);
    in_port[0] = 1'b1; cycle(); cycle();
    n_chk++;
    if (irq_o[3] !== 1'b0) begin n_fail++; $display("FAIL level_lat got %b want 0", irq_o[3]); end
    cycle();
    n_chk++;
    if (irq_o[3] !== 1'b1) begin n_fail++; $display("FAIL level_set got %b want 1", irq_o[3]); end
    in_port[0] = 1'b0; cycle(); cycle();
    n_chk++;
    if (irq_o[3] !== 1'b1) begin n_fail++; $display("FAIL level_hold got %b want 1", irq_o[3]); end
    cycle();
    n_chk++;
    if (irq_o[3] !== 1'b0) begin n_fail++; $display("FAIL level_clr got %b want 0", irq_o[3]); end
  endtask

  task automatic test_reads();
    in_port = '1; repeat (4) cycle();
    bus_write(2'd1, 32'hFFFF_FFFF);
    address = 2'd1; cycle();
    for (int k = 0; k < NI; k++) begin
      n_chk++;
      if (rd[k] !== 32'd0) begin n_fail++; $display("FAIL rsvd dut%0d got %h want 0", k, rd[k]); end
    end
    bus_write(2'd0, 32'hFFFF_FFFF);
    cycle();
    n_chk++;
    if (rd[0] !== 32'h0000_00FF) begin n_fail++; $display("FAIL data_hi_zero got %h want 000000ff", rd[0]); end
    bus_write(2'd2, 32'hFFFF_FFFF);
    cycle();
    n_chk++;
    if (rd[0] !== 32'h0000_00FF) begin n_fail++; $display("FAIL mask_width got %h want 000000ff", rd[0]); end
  endtask

  task automatic test_random();
    repeat (400) begin
      in_port    = W'($urandom);
      address    = 2'($urandom);
      chipselect = ($urandom_range(3) == 0);
      write_n    = ($urandom_range(1) == 0);
      writedata  = $urandom;
      cycle();
      for (int k = 0; k < NI; k++) begin
        n_chk++;
        if (rd[k] !== m_rd[k] || irq_o[k] !== m_irq[k]) begin
          n_fail++; $display("FAIL random dut%0d rd=%h irq=%b want rd=%h irq=%b", k, rd[k], irq_o[k], m_rd[k], m_irq[k]);
        end
      end
    end
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic test_mid_reset();
    bus_write(2'd2, 32'hFF); bus_write(2'd3, 32'hFF);
    address = 2'd3; in_port = 8'h00; repeat (4) cycle();
    in_port = 8'h0F; repeat (5) cycle();
    reset_n = 1'b0; model_reset();
    #1;
    for (int k = 0; k < NI; k++) begin
      n_chk++;
      if (rd[k] !== 32'd0 || irq_o[k] !== 1'b0) begin
        n_fail++; $display("FAIL async_reset dut%0d rd=%h irq=%b want rd=0 irq=0", k, rd[k], irq_o[k]);
      end
    end
    in_port = '1; cycle(); cycle();
    reset_n = 1'b1;
    repeat (6) begin
      cycle();
      for (int k = 0; k < NI; k++) begin
        n_chk++;
        if (rd[k] !== m_rd[k] || irq_o[k] !== m_irq[k]) begin
          n_fail++; $display("FAIL rewarm dut%0d rd=%h irq=%b want rd=%h irq=%b", k, rd[k], irq_o[k], m_rd[k], m_irq[k]);
        end
      end
    end
    n_chk++;
    if (rd[0] !== 32'd0 || irq_o[0] !== 1'b0) begin
      n_fail++; $display("FAIL rewarm_quiet rd=%h irq=%b want rd=0 irq=0", rd[0], irq_o[0]);
    end
  endtask

  initial begin
    test_reset();
    test_rise();
    test_set_wins();
    test_any();
    test_level();
    test_reads();
    test_random();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
